// File: rtl/vec_mem_pkg.sv
// Shared types and helpers for the vector co-processor data memory.
package vec_mem_pkg;

    localparam int MAX_MEM_LAT = 4;

    typedef enum logic [2:0] {
        W8  = 3'b000,
        W16 = 3'b101,
        W32 = 3'b110
    } mem_width_e;

    // Legal size/offset pairs: bytes anywhere, halves on even offsets, words aligned.
    function automatic logic width_legal(input logic [2:0] width, input logic [1:0] offset);
        case (width)
            W8:      return 1'b1;
            W16:     return !offset[0];
            W32:     return offset == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vec_mem_rd_pipe.sv
// LAT-stage valid/data delay line; each stage's data only advances with its valid,
// so the output data holds its last returned value while valid is low.
module vec_mem_rd_pipe #(
    parameter int LAT = 2,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [LAT:1]        vld_pipe, vld_prev;
    logic [LAT:1][W-1:0] dat_pipe, dat_prev;

    for (genvar i = 1; i <= LAT; i++) begin : g_stage
        if (i == 1) begin : g_head
            assign vld_prev[i] = in_valid;
            assign dat_prev[i] = in_data;
        end else begin : g_body
            assign vld_prev[i] = vld_pipe[i-1];
            assign dat_prev[i] = dat_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= vld_prev;
            for (int i = 1; i <= LAT; i++)
                if (vld_prev[i]) dat_pipe[i] <= dat_prev[i];
        end
    end

    assign out_valid = vld_pipe[LAT];
    assign out_data  = dat_pipe[LAT];

endmodule

// File: rtl/vec_data_mem.sv
// Behavioural data memory behind the vector LSU: byte/half/word stores, aligned
// zero-extended loads returned after LAT cycles, one-cycle error strobe on rejects.
module vec_data_mem
    import vec_mem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEW   = 32,
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [XLEN-1:0] lsu2mem_addr,
    input  logic            ld_req,
    input  logic            st_req,
    input  logic [2:0]      width,
    input  logic [SEW-1:0]  lsu2mem_data,
    output logic [SEW-1:0]  mem2lsu_data,
    output logic            mem2lsu_valid,
    output logic            mem_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = SEW / 8;

    logic [SEW-1:0] mem [DEPTH];

    logic [AW-1:0]  idx;
    logic [1:0]     off;
    logic           legal, reject, we;
    logic [NB-1:0]  be;
    logic [SEW-1:0] wdata, rd_word, shifted, rd_data;
    logic           unused_addr;

    assign idx         = lsu2mem_addr[AW+1:2];
    assign off         = lsu2mem_addr[1:0];
    assign unused_addr = ^lsu2mem_addr[XLEN-1:AW+2];

    // Simultaneous load+store is rejected, which is why a load never races a store.
    assign legal  = width_legal(width, off);
    assign reject = (ld_req | st_req) & (!legal | (ld_req & st_req));
    assign we     = st_req & !ld_req & legal;

    always_comb begin
        be    = '0;
        wdata = lsu2mem_data;
        case (width)
            W8: begin
                be    = {{(NB-1){1'b0}}, 1'b1} << off;
                wdata = {NB{lsu2mem_data[7:0]}};
            end
            W16: begin
                be    = {{(NB-2){1'b0}}, 2'b11} << off;
                wdata = {(NB/2){lsu2mem_data[15:0]}};
            end
            W32:     be = '1;
            default: be = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rd_word = mem[idx];
    assign shifted = rd_word >> {off, 3'b000};

    // Rejected loads still return an element (zero) to keep LSU counts aligned.
    always_comb begin
        rd_data = '0;
        if (ld_req && !reject) begin
            case (width)
                W8:      rd_data[7:0]  = shifted[7:0];
                W16:     rd_data[15:0] = shifted[15:0];
                W32:     rd_data       = shifted;
                default: rd_data       = '0;
            endcase
        end
    end

    vec_mem_rd_pipe #(.LAT(LAT), .W(SEW)) u_rd_pipe (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (ld_req),
        .in_data   (rd_data),
        .out_valid (mem2lsu_valid),
        .out_data  (mem2lsu_data)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) mem_err <= 1'b0;
        else        mem_err <= reject;
    end

endmodule
